// File: rtl/dtc_rx_aligner.sv
// DTC link word aligner: finds the bit offset of the idle sync word in the deserializer stream and delivers aligned words plus a lock flag.
// Optional lock-loss statistics counter enabled by defining DTC_ALIGN_STATS_EN.

module dtc_rx_aligner_cmp #(
  parameter logic [15:0] SYNC_WORD = 16'hBC50
) (
  input  logic [15:0] i_cand,
  output logic        o_hit
);
  assign o_hit = (i_cand == SYNC_WORD);
endmodule

module dtc_rx_aligner #(
  parameter logic [15:0] SYNC_WORD    = 16'hBC50,
  parameter int          LOCK_CNT     = 4,
  parameter int          UNLOCK_CNT   = 4,
  parameter int          SYNC_TIMEOUT = 1024
) (
  input  logic        bitclkdiv,
  input  logic        reset,
  input  logic [15:0] raw_din,
  output logic [15:0] dtc_deser_dout,
  output logic        dtc_deser_align,
  output logic [3:0]  align_offset
`ifdef DTC_ALIGN_STATS_EN
  ,
  output logic [7:0]  lock_loss_cnt
`endif
);

  localparam int NUM_OFF = 16;

  typedef enum logic [2:0] {
    S_SEARCH = 3'b001,
    S_VERIFY = 3'b010,
    S_LOCKED = 3'b100
  } state_t;

  state_t r_state, w_state_nxt;

  logic [15:0]               r_d1, r_d2, r_dout;
  logic [30:0]               w_win;
  logic [NUM_OFF-1:0][15:0]  w_cand;
  logic [NUM_OFF-1:0]        w_match;
  logic [3:0]                w_first;
  logic [3:0]                r_off, r_hit, r_miss;
  logic [15:0]               r_wd;
  logic                      w_any, w_hit_off, w_wd_exp;
  logic                      w_hit_done, w_miss_done, w_leave_lock;

  always_ff @(posedge bitclkdiv or negedge reset) begin
    if (!reset) begin
      r_d1   <= '0;
      r_d2   <= '0;
      r_dout <= '0;
    end else begin
      r_d1   <= raw_din;
      r_d2   <= r_d1;
      r_dout <= w_cand[r_off];
    end
  end

  // d1[15] can never be inside a 16-bit candidate, so the window stops at bit 30.
  assign w_win = {r_d1[14:0], r_d2};

  for (genvar k = 0; k < NUM_OFF; k++) begin : g_off
    assign w_cand[k] = w_win[k +: 16];
    dtc_rx_aligner_cmp #(.SYNC_WORD(SYNC_WORD)) u_cmp (
      .i_cand (w_cand[k]),
      .o_hit  (w_match[k])
    );
  end

  always_comb begin
    w_first = '0;
    for (int k = NUM_OFF - 1; k >= 0; k--)
      if (w_match[k]) w_first = 4'(k);
  end

  assign w_any       = |w_match;
  assign w_hit_off   = w_match[r_off];
  assign w_wd_exp    = (r_wd == 16'(SYNC_TIMEOUT - 1));
  assign w_hit_done  = (({1'b0, r_hit} + 5'd1) == 5'(LOCK_CNT));
  assign w_miss_done = (({1'b0, r_miss} + 5'd1) == 5'(UNLOCK_CNT));

  always_ff @(posedge bitclkdiv or negedge reset) begin
    if (!reset) r_state <= S_SEARCH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_SEARCH: begin
        if (w_any) w_state_nxt = (LOCK_CNT == 1) ? S_LOCKED : S_VERIFY;
      end
      S_VERIFY: begin
        if (w_hit_off) begin
          if (w_hit_done) w_state_nxt = S_LOCKED;
        end else if (w_any || w_wd_exp) begin
          w_state_nxt = S_SEARCH;
        end
      end
      S_LOCKED: begin
        if (!w_hit_off && w_wd_exp && w_miss_done) w_state_nxt = S_SEARCH;
      end
      default: w_state_nxt = S_SEARCH;
    endcase
  end

  always_comb begin
    dtc_deser_align = (r_state == S_LOCKED);
  end

  assign dtc_deser_dout = r_dout;
  assign align_offset   = r_off;
  assign w_leave_lock   = (r_state == S_LOCKED) && (w_state_nxt == S_SEARCH);

  // An on-offset sync always wins over a simultaneous watchdog expiry.
  always_ff @(posedge bitclkdiv or negedge reset) begin
    if (!reset) begin
      r_off  <= '0;
      r_hit  <= '0;
      r_miss <= '0;
      r_wd   <= '0;
    end else begin
      case (r_state)
        S_SEARCH: begin
          r_wd   <= '0;
          r_miss <= '0;
          if (w_any) begin
            r_off <= w_first;
            r_hit <= 4'd1;
          end else begin
            r_hit <= '0;
          end
        end
        S_VERIFY: begin
          if (w_hit_off) begin
            r_hit <= r_hit + 4'd1;
            r_wd  <= '0;
          end else if (w_any || w_wd_exp) begin
            r_wd  <= '0;
          end else begin
            r_wd  <= r_wd + 16'd1;
          end
        end
        S_LOCKED: begin
          if (w_hit_off) begin
            r_wd   <= '0;
            r_miss <= '0;
          end else if (w_wd_exp) begin
            r_wd   <= '0;
            r_miss <= w_miss_done ? 4'd0 : r_miss + 4'd1;
          end else begin
            r_wd   <= r_wd + 16'd1;
          end
        end
        default: begin
          r_wd   <= '0;
          r_hit  <= '0;
          r_miss <= '0;
        end
      endcase
    end
  end

`ifdef DTC_ALIGN_STATS_EN
  logic [7:0] r_loss;

  always_ff @(posedge bitclkdiv or negedge reset) begin
    if (!reset)                              r_loss <= '0;
    else if (w_leave_lock && r_loss != 8'hFF) r_loss <= r_loss + 8'd1;
  end

  assign lock_loss_cnt = r_loss;
`else
  logic w_unused_leave;
  assign w_unused_leave = w_leave_lock;
`endif

endmodule

// File: tb/tb_dtc_rx_aligner.sv
// Directed bench for dtc_rx_aligner: lock at offsets 0/5, disturbed verify, link loss, miss recovery, async reset.
module tb_dtc_rx_aligner;

  localparam logic [15:0] SYNC = 16'hBC50;
  localparam logic [15:0] FILL = 16'h1234;

  logic        bitclkdiv = 1'b0;
  logic        reset     = 1'b1;
  logic [15:0] raw_din   = '0;
  logic [15:0] dtc_deser_dout;
  logic        dtc_deser_align;
  logic [3:0]  align_offset;
`ifdef DTC_ALIGN_STATS_EN
  logic [7:0]  lock_loss_cnt;
`endif

  dtc_rx_aligner dut (
    .bitclkdiv       (bitclkdiv),
    .reset           (reset),
    .raw_din         (raw_din),
    .dtc_deser_dout  (dtc_deser_dout),
    .dtc_deser_align (dtc_deser_align),
    .align_offset    (align_offset)
`ifdef DTC_ALIGN_STATS_EN
    ,
    .lock_loss_cnt   (lock_loss_cnt)
`endif
  );

  always #5 bitclkdiv = ~bitclkdiv;

  int          ncmp = 0;
  int          nerr = 0;
  logic [15:0] prev = '0;
  int          sh   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Aligned stream word in, raw word shifted by sh bits out; samples 1 time unit after the edge.
  task automatic send(input logic [15:0] word);
    logic [31:0] cat;
    cat     = {word, prev} >> (16 - sh);
    raw_din = cat[15:0];
    prev    = word;
    @(posedge bitclkdiv);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) send(FILL);
  endtask

  task automatic frame();
    send(SYNC);
    idle(7);
  endtask

  // Four syncs 8 cycles apart; align must rise exactly two edges after the 4th sync is driven.
  task automatic lock_up(input string tag);
    repeat (3) frame();
    send(SYNC);
    send(FILL);
    chk({tag, "_prelock"}, {31'd0, dtc_deser_align}, 32'd0);
    send(FILL);
    chk({tag, "_lock"}, {31'd0, dtc_deser_align}, 32'd1);
    chk({tag, "_lockdout"}, {16'd0, dtc_deser_dout}, {16'd0, SYNC});
  endtask

  task automatic do_reset(input int shift);
    @(negedge bitclkdiv);
    reset   = 1'b0;
    raw_din = '0;
    prev    = '0;
    sh      = shift;
    repeat (2) @(negedge bitclkdiv);
    reset   = 1'b1;
  endtask

  initial begin
    // reset state
    #2 reset = 1'b0;
    #1;
    chk("rst_align", {31'd0, dtc_deser_align}, 32'd0);
    chk("rst_dout", {16'd0, dtc_deser_dout}, 32'd0);
    chk("rst_off", {28'd0, align_offset}, 32'd0);
`ifdef DTC_ALIGN_STATS_EN
    chk("rst_loss", {24'd0, lock_loss_cnt}, 32'd0);
`endif
    repeat (2) @(negedge bitclkdiv);
    reset = 1'b1;

    // offset 0
    sh = 0;
    lock_up("off0");
    chk("off0_off", {28'd0, align_offset}, 32'd0);
    send(16'hA5A5);
    send(16'h0F0F);
    send(FILL);
    chk("off0_dly_a", {16'd0, dtc_deser_dout}, 32'h0000A5A5);
    send(FILL);
    chk("off0_dly_b", {16'd0, dtc_deser_dout}, 32'h00000F0F);
    send(FILL);
    chk("off0_dly_c", {16'd0, dtc_deser_dout}, {16'd0, FILL});

    // offset 5
    do_reset(5);
    lock_up("off5");
    chk("off5_off", {28'd0, align_offset}, 32'd5);
    send(16'hF7F7);
    send(FILL);
    send(FILL);
    chk("off5_word", {16'd0, dtc_deser_dout}, 32'h0000F7F7);
    chk("off5_hold", {31'd0, dtc_deser_align}, 32'd1);

    // verify disturbed: two syncs at 3, then syncs at 9
    do_reset(3);
    send(SYNC);
    send(FILL);
    send(FILL);
    chk("dist_off3", {28'd0, align_offset}, 32'd3);
    idle(5);
    frame();
    send(16'h0000);
    send(16'h0000);
    sh = 9;
    send(FILL);
    send(SYNC);
    send(FILL);
    send(FILL);
    chk("dist_keep3", {28'd0, align_offset}, 32'd3);
    chk("dist_noal", {31'd0, dtc_deser_align}, 32'd0);
    idle(5);
    send(SYNC);
    send(FILL);
    send(FILL);
    chk("dist_off9", {28'd0, align_offset}, 32'd9);
    idle(5);
    repeat (2) frame();
    send(SYNC);
    send(FILL);
    chk("dist_prelock", {31'd0, dtc_deser_align}, 32'd0);
    send(FILL);
    chk("dist_lock", {31'd0, dtc_deser_align}, 32'd1);
    chk("dist_lockoff", {28'd0, align_offset}, 32'd9);

    // link loss: align falls 4096 edges after the last registered sync
    do_reset(0);
    lock_up("loss");
    idle(4095);
    chk("loss_hold", {31'd0, dtc_deser_align}, 32'd1);
    send(FILL);
    chk("loss_fall", {31'd0, dtc_deser_align}, 32'd0);
    chk("loss_offkept", {28'd0, align_offset}, 32'd0);
`ifdef DTC_ALIGN_STATS_EN
    chk("loss_cnt", {24'd0, lock_loss_cnt}, 32'd1);
`endif

    // a sync after one miss clears the miss count
    do_reset(0);
    lock_up("rec");
    idle(1533);
    send(SYNC);
    send(FILL);
    chk("rec_hold_a", {31'd0, dtc_deser_align}, 32'd1);
    send(FILL);
    chk("rec_hold_b", {31'd0, dtc_deser_align}, 32'd1);
    idle(3073);
    chk("rec_missclr", {31'd0, dtc_deser_align}, 32'd1);
    idle(1022);
    chk("rec_hold_c", {31'd0, dtc_deser_align}, 32'd1);
    send(FILL);
    chk("rec_fall", {31'd0, dtc_deser_align}, 32'd0);

    // async reset mid-lock, between edges
    do_reset(5);
    lock_up("ar");
    send(FILL);
    #2 reset = 1'b0;
    #1;
    chk("ar_align", {31'd0, dtc_deser_align}, 32'd0);
    chk("ar_dout", {16'd0, dtc_deser_dout}, 32'd0);
    chk("ar_off", {28'd0, align_offset}, 32'd0);
    #3 reset = 1'b1;
    prev = '0;
    lock_up("ar_relock");
    chk("ar_reloff", {28'd0, align_offset}, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
